// File: rtl/vend_dispense_ctrl.sv
// Actuator sequencer behind the vending FSM: one order drives the soda motor,
// then the nickel ejector once per coin, each pulse waiting for its ack.
module vend_dispense_ctrl #(
  parameter int unsigned CHANGE_W       = 3,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TOTAL_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vend_valid_i,
  output logic                vend_ready_o,
  input  logic                soda_i,
  input  logic [CHANGE_W-1:0] change_i,
  output logic                soda_motor_o,
  input  logic                soda_done_i,
  output logic                coin_eject_o,
  input  logic                coin_done_i,
  output logic                vend_done_o,
  output logic                busy_o,
  output logic                fault_o,
  input  logic                fault_clr_i,
  output logic [TOTAL_W-1:0]  total_coins_o
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SODA_PULSE = 3'd1;
  localparam logic [2:0] SODA_WAIT  = 3'd2;
  localparam logic [2:0] COIN_PULSE = 3'd3;
  localparam logic [2:0] COIN_WAIT  = 3'd4;
  localparam logic [2:0] FAULT      = 3'd5;

  // One counter serves both pulse length and ack timeout; it restarts on every state entry.
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [CHANGE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q + 1'b1;
    total_d = total_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (vend_valid_i) begin
          rem_d = change_i;
          if (soda_i)                state_d = SODA_PULSE;
          else if (change_i != '0)   state_d = COIN_PULSE;
        end
      end
      SODA_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = SODA_WAIT;
          cnt_d   = '0;
        end
      end
      SODA_WAIT: begin
        if (soda_done_i) begin
          cnt_d = '0;
          if (rem_q != '0) begin
            state_d = COIN_PULSE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
      end
      COIN_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = COIN_WAIT;
          cnt_d   = '0;
        end
      end
      COIN_WAIT: begin
        // An ack arriving in the expiry cycle takes priority over the timeout.
        if (coin_done_i) begin
          cnt_d   = '0;
          rem_d   = rem_q - 1'b1;
          total_d = total_q + 1'b1;
          if (rem_q == CHANGE_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = COIN_PULSE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        cnt_d = '0;
        if (fault_clr_i) begin
          state_d = IDLE;
          rem_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      done_q  <= done_d;
    end
  end

  assign vend_ready_o  = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign soda_motor_o  = (state_q == SODA_PULSE);
  assign coin_eject_o  = (state_q == COIN_PULSE);
  assign fault_o       = (state_q == FAULT);
  assign vend_done_o   = done_q;
  assign total_coins_o = total_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Randomized bench for vend_dispense_ctrl: an actuator model answers pulses,
// orders push expected events into a scoreboard, and a monitor pops and compares.
module tb_vend_dispense_ctrl;

  localparam int CW = 3;
  localparam int P  = 4;
  localparam int T  = 255;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          vend_valid_i;
  logic          vend_ready_o;
  logic          soda_i;
  logic [CW-1:0] change_i;
  logic          soda_motor_o;
  logic          soda_done_i;
  logic          coin_eject_o;
  logic          coin_done_i;
  logic          vend_done_o;
  logic          busy_o;
  logic          fault_o;
  logic          fault_clr_i;
  logic [TW-1:0] total_coins_o;

  vend_dispense_ctrl #(
    .CHANGE_W(CW), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .TOTAL_W(TW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .vend_valid_i(vend_valid_i), .vend_ready_o(vend_ready_o),
    .soda_i(soda_i), .change_i(change_i),
    .soda_motor_o(soda_motor_o), .soda_done_i(soda_done_i),
    .coin_eject_o(coin_eject_o), .coin_done_i(coin_done_i),
    .vend_done_o(vend_done_o), .busy_o(busy_o),
    .fault_o(fault_o), .fault_clr_i(fault_clr_i),
    .total_coins_o(total_coins_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_SODA, EV_COIN, EV_DONE, EV_FAULT} ev_kind_e;
  typedef struct { ev_kind_e kind; int total; } ev_t;

  ev_t exp_q[$];
  int  model_total;
  int  tests;
  int  fails;

  // Actuator model controls
  int  soda_delay;
  int  coin_delay;
  bit  stray_en;
  bit  clr_req;
  int  coin_acks;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Reference model: an order expands into the actuator events it must produce.
  task automatic expect_order(input bit soda, input int chg, input bit soda_to, input bit coin_to);
    ev_t e;
    e.total = 0;
    if (soda) begin
      e.kind = EV_SODA; exp_q.push_back(e);
      if (soda_to) begin
        e.kind = EV_FAULT; exp_q.push_back(e);
        return;
      end
    end
    if (coin_to && chg != 0) begin
      e.kind = EV_COIN;  exp_q.push_back(e);
      e.kind = EV_FAULT; exp_q.push_back(e);
      return;
    end
    for (int i = 0; i < chg; i++) begin
      e.kind = EV_COIN; exp_q.push_back(e);
    end
    model_total = (model_total + chg) % (1 << TW);
    if (soda || chg != 0) begin
      e.kind  = EV_DONE;
      e.total = model_total;
      exp_q.push_back(e);
    end
  endtask

  // Actuator model: acks each pulse a programmable number of cycles into the WAIT phase.
  initial begin : actuator
    bit s_prev, c_prev, s_pend, c_pend;
    int s_cnt, c_cnt;
    s_prev = 0; c_prev = 0; s_pend = 0; c_pend = 0; s_cnt = 0; c_cnt = 0;
    soda_done_i = 0; coin_done_i = 0; fault_clr_i = 0;
    forever begin
      @(posedge clk); #1;
      soda_done_i = 0; coin_done_i = 0; fault_clr_i = 0;
      if (!rst_ni) begin
        s_prev = 0; c_prev = 0; s_pend = 0; c_pend = 0;
        continue;
      end
      if (fault_o) begin
        s_pend = 0; c_pend = 0;
        fault_clr_i = clr_req;
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        fault_clr_i = 1;
      end
      if (s_prev && !soda_motor_o) begin s_pend = 1; s_cnt = soda_delay; end
      if (c_prev && !coin_eject_o) begin c_pend = 1; c_cnt = coin_delay; end
      s_prev = soda_motor_o;
      c_prev = coin_eject_o;
      if (s_pend) begin
        if (s_cnt <= 1) begin soda_done_i = 1; s_pend = 0; end
        else s_cnt--;
      end
      if (c_pend) begin
        if (c_cnt <= 1) begin coin_done_i = 1; c_pend = 0; coin_acks++; end
        else c_cnt--;
      end
      // Acks while a drive is active must be ignored by the controller.
      if (stray_en && (soda_motor_o || coin_eject_o) && $urandom_range(0, 2) == 0) begin
        soda_done_i = 1;
        coin_done_i = 1;
      end
    end
  end

  task automatic pop_expect(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      fail_now($sformatf("unexpected_event kind=%0d total=%0d", kind, total_coins_o));
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == EV_DONE && e.kind == EV_DONE)
      check("total_at_done", int'(total_coins_o), e.total);
  endtask

  // Monitor: turns DUT outputs into events and checks them against the scoreboard.
  initial begin : monitor
    int s_len, c_len;
    bit f_prev;
    s_len = 0; c_len = 0; f_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        s_len = 0; c_len = 0; f_prev = 0;
        continue;
      end
      check("busy_vs_ready", busy_o, !vend_ready_o);
      if (soda_motor_o) s_len++;
      else if (s_len != 0) begin
        check("soda_pulse_len", s_len, P);
        pop_expect(EV_SODA);
        s_len = 0;
      end
      if (coin_eject_o) c_len++;
      else if (c_len != 0) begin
        check("coin_pulse_len", c_len, P);
        pop_expect(EV_COIN);
        c_len = 0;
      end
      if (vend_done_o) pop_expect(EV_DONE);
      if (fault_o && !f_prev) pop_expect(EV_FAULT);
      f_prev = fault_o;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic run_order(input bit soda, input int chg, input bit soda_to, input bit coin_to,
                           input bit keep_valid);
    int guard;
    guard = 0;
    vend_valid_i = 1;
    soda_i       = soda;
    change_i     = CW'(chg);
    while (!vend_ready_o && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!vend_ready_o) begin
      fail_now("order_accept_timeout");
      vend_valid_i = 0;
      return;
    end
    expect_order(soda, chg, soda_to, coin_to);
    @(negedge clk);
    if (!keep_valid) vend_valid_i = 0;
    if (soda || chg != 0) begin
      check("ready_low_while_busy", vend_ready_o, 0);
      check("busy_after_accept", busy_o, 1);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(vend_ready_o && exp_q.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!(vend_ready_o && exp_q.size() == 0))
      fail_now($sformatf("idle_timeout pending=%0d ready=%0d", exp_q.size(), vend_ready_o));
  endtask

  task automatic clear_fault();
    int guard;
    guard = 0;
    while (!fault_o && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("fault_raised", fault_o, 1);
    check("ready_in_fault", vend_ready_o, 0);
    check("drives_off_in_fault", {soda_motor_o, coin_eject_o}, 0);
    clr_req = 1;
    guard = 0;
    while (!vend_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    clr_req = 0;
    check("ready_after_clear", vend_ready_o, 1);
    check("fault_after_clear", fault_o, 0);
    check("total_after_fault", int'(total_coins_o), model_total);
    if (exp_q.size() != 0) fail_now("events_left_after_fault");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base_acks;
    int pre_total;
    tests = 0; fails = 0; model_total = 0; coin_acks = 0;
    soda_delay = 3; coin_delay = 3; stray_en = 0; clr_req = 0;
    rst_ni = 0; vend_valid_i = 0; soda_i = 0; change_i = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", vend_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_motor", soda_motor_o, 0);
    check("rst_eject", coin_eject_o, 0);
    check("rst_done", vend_done_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_total", int'(total_coins_o), 0);
    rst_ni = 1;
    @(negedge clk);

    // Soda plus two nickels, acks three cycles into each wait.
    run_order(1, 2, 0, 0, 0);
    wait_idle();
    check("total_after_first", int'(total_coins_o), 2);

    // Empty order: accepted but nothing happens.
    run_order(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("empty_busy", busy_o, 0);
      check("empty_drives", {soda_motor_o, coin_eject_o, vend_done_o}, 0);
      @(negedge clk);
    end

    // Soda ack withheld: timeout, fault, clear.
    soda_delay = 100000;
    run_order(1, 0, 1, 0, 0);
    clear_fault();
    soda_delay = 3;

    // Coin ack exactly in the expiry cycle wins; stray acks during pulses ignored.
    stray_en   = 1;
    coin_delay = T;
    run_order(0, 2, 0, 0, 0);
    wait_idle();
    check("no_fault_on_expiry_ack", fault_o, 0);

    // One cycle later than expiry is a fault.
    coin_delay = T + 1;
    run_order(1, 2, 0, 1, 0);
    clear_fault();
    coin_delay = 2;

    // Reset after the third ack of a seven-nickel order.
    pre_total = model_total;
    base_acks = coin_acks;
    run_order(0, 7, 0, 0, 0);
    for (int g = 0; g < 1000 && coin_acks < base_acks + 3; g++) @(negedge clk);
    if (coin_acks < base_acks + 3) fail_now("third_ack_timeout");
    @(posedge clk); #2;
    check("total_before_reset", int'(total_coins_o), (pre_total + 3) % (1 << TW));
    rst_ni = 0;
    #1;
    check("midrst_ready", vend_ready_o, 1);
    check("midrst_busy", busy_o, 0);
    check("midrst_drives", {soda_motor_o, coin_eject_o, vend_done_o, fault_o}, 0);
    check("midrst_total", int'(total_coins_o), 0);
    exp_q.delete();
    model_total = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    run_order(1, 3, 0, 0, 0);
    wait_idle();
    check("total_after_reset_order", int'(total_coins_o), 3);

    // Randomized orders, sometimes with valid held across orders.
    for (int i = 0; i < 40; i++) begin
      bit soda;
      int chg;
      bit keep;
      soda       = 1'($urandom_range(0, 1));
      chg        = (i == 5 || i == 17) ? 7 : int'($urandom_range(0, 7));
      keep       = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      soda_delay = int'($urandom_range(1, 8));
      coin_delay = int'($urandom_range(1, 8));
      run_order(soda, chg, 0, 0, keep);
    end
    wait_idle();
    check("final_total", int'(total_coins_o), model_total);
    check("final_fault", fault_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
